// File: rtl/manifest_pkg.sv
// Shared types and constants for the firmware-manifest ROM read sequencer.
package manifest_pkg;
  localparam int ADDR_WIDTH = 10;
  localparam int DATA_WIDTH = 32;
  localparam int LEN_WIDTH  = 8;
  localparam int DEFAULT_PREFETCH_DEPTH = 2;
  localparam logic [DATA_WIDTH-1:0] DEFAULT_UNDERRUN_WORD = 32'hDEAD_BEEF;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [LEN_WIDTH:0]    remain_t;

  typedef enum logic [3:0] {
    OP_READ_SINGLE = 4'hA,
    OP_READ_BURST  = 4'hB
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } seq_state_e;

  function automatic logic is_read_op(input logic [3:0] op);
    return (op == OP_READ_SINGLE) || (op == OP_READ_BURST);
  endfunction
endpackage

// File: rtl/manifest_prefetch_fifo.sv
// Show-ahead synchronous FIFO with flush; the caller guarantees no push when full.
module manifest_prefetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]  mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W:0]    count_r;
  logic              do_pop_s;

  assign do_pop_s  = pop && (count_r != '0);
  assign head_data = mem_r[rd_ptr_r];
  assign occupancy = count_r;

  // Storage array, no reset needed since pointers qualify it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (srst || flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/manifest_read_sequencer.sv
// Sequences single/burst manifest ROM reads for the JTAG USER chain and keeps
// a small prefetch buffer so a word is ready at each Capture-DR.
module manifest_read_sequencer
  import manifest_pkg::*;
#(
  parameter int    PREFETCH_DEPTH = DEFAULT_PREFETCH_DEPTH,
  parameter data_t UNDERRUN_WORD  = DEFAULT_UNDERRUN_WORD
) (
  input  logic                  tck,
  input  logic                  tap_test_logic_reset,
  input  logic                  cmd_valid,
  input  logic [3:0]            cmd_opcode,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  word_take,
  output logic [DATA_WIDTH-1:0] word_data,
  output logic                  word_avail,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  busy,
  output logic                  underrun,
  output logic                  cmd_ignored
);
  localparam int OCC_W = $clog2(PREFETCH_DEPTH);
  localparam int CNT_W = OCC_W + 2;

  seq_state_e       state_r, state_s;
  addr_t            next_addr_r, next_addr_s;
  remain_t          remaining_r, remaining_s;
  logic             rom_en_r, rom_en_s;
  addr_t            rom_addr_r, rom_addr_s;
  logic             ret_pending_r, ret_kill_r;
  logic             underrun_r, cmd_ignored_r;
  logic             accept_s, push_s, pop_s, live_ret_s, credit_ok_s;
  logic [OCC_W:0]   occ_s;
  data_t            head_s;
  logic [CNT_W-1:0] credit_used_s;

  assign accept_s    = cmd_valid && is_read_op(cmd_opcode);
  assign pop_s       = word_take && (occ_s != '0);
  // A return whose request predates the latest command is dropped on arrival.
  assign live_ret_s  = ret_pending_r && !ret_kill_r;
  assign push_s      = live_ret_s && !accept_s;
  assign credit_used_s = CNT_W'(occ_s) + CNT_W'(rom_en_r) + CNT_W'(live_ret_s);
  assign credit_ok_s = credit_used_s < CNT_W'(PREFETCH_DEPTH);

  manifest_prefetch_fifo #(
    .DEPTH (PREFETCH_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk       (tck),
    .srst      (tap_test_logic_reset),
    .flush     (accept_s),
    .push      (push_s),
    .push_data (rom_data),
    .pop       (pop_s),
    .head_data (head_s),
    .occupancy (occ_s)
  );

  // Next-state, issue decision and address/length bookkeeping.
  always_comb begin
    state_s     = state_r;
    next_addr_s = next_addr_r;
    remaining_s = remaining_r;
    rom_en_s    = 1'b0;
    rom_addr_s  = rom_addr_r;
    if (accept_s) begin
      rom_en_s    = 1'b1;
      rom_addr_s  = cmd_addr;
      next_addr_s = cmd_addr + 1'b1;
      remaining_s = (cmd_opcode == OP_READ_BURST) ? {1'b0, cmd_len} : '0;
      state_s     = FETCH;
    end else begin
      case (state_r)
        IDLE: state_s = IDLE;
        FETCH: begin
          if (remaining_r == '0) begin
            state_s = DRAIN;
          end else if (credit_ok_s) begin
            rom_en_s    = 1'b1;
            rom_addr_s  = next_addr_r;
            next_addr_s = next_addr_r + 1'b1;
            remaining_s = remaining_r - 1'b1;
            state_s     = (remaining_r == {{LEN_WIDTH{1'b0}}, 1'b1}) ? DRAIN : FETCH;
          end else begin
            state_s = FETCH;
          end
        end
        DRAIN: begin
          if ((occ_s == '0) && !rom_en_r && !ret_pending_r) begin
            state_s = IDLE;
          end else begin
            state_s = DRAIN;
          end
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // Registered state, ROM strobe, return tracking and status flags.
  always_ff @(posedge tck) begin
    if (tap_test_logic_reset) begin
      state_r       <= IDLE;
      next_addr_r   <= '0;
      remaining_r   <= '0;
      rom_en_r      <= 1'b0;
      rom_addr_r    <= '0;
      ret_pending_r <= 1'b0;
      ret_kill_r    <= 1'b0;
      underrun_r    <= 1'b0;
      cmd_ignored_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      next_addr_r   <= next_addr_s;
      remaining_r   <= remaining_s;
      rom_en_r      <= rom_en_s;
      rom_addr_r    <= rom_addr_s;
      ret_pending_r <= rom_en_r;
      ret_kill_r    <= accept_s;
      underrun_r    <= underrun_r || (word_take && (occ_s == '0));
      cmd_ignored_r <= cmd_valid && !is_read_op(cmd_opcode);
    end
  end

  assign word_avail  = (occ_s != '0);
  assign word_data   = word_avail ? head_s : UNDERRUN_WORD;
  assign rom_en      = rom_en_r;
  assign rom_addr    = rom_addr_r;
  assign busy        = (state_r != IDLE);
  assign underrun    = underrun_r;
  assign cmd_ignored = cmd_ignored_r;
endmodule

// File: tb/tb_manifest_read_sequencer.sv
// Self-checking bench: randomized read commands against a queue-based model of the manifest ROM.
module tb_manifest_read_sequencer;
  logic        tck = 1'b0;
  logic        tap_test_logic_reset;
  logic        cmd_valid;
  logic [3:0]  cmd_opcode;
  logic [9:0]  cmd_addr;
  logic [7:0]  cmd_len;
  logic        word_take;
  logic [31:0] word_data;
  logic        word_avail;
  logic        rom_en;
  logic [9:0]  rom_addr;
  logic [31:0] rom_data;
  logic        busy;
  logic        underrun;
  logic        cmd_ignored;

  int checks = 0;
  int errors = 0;

  logic [31:0] rom [1024];
  logic [31:0] got_q[$];
  logic [9:0]  iss_q[$];
  int          max_out;
  int          ign_pulses;
  bit          timed_out;

  manifest_read_sequencer dut (
    .tck                  (tck),
    .tap_test_logic_reset (tap_test_logic_reset),
    .cmd_valid            (cmd_valid),
    .cmd_opcode           (cmd_opcode),
    .cmd_addr             (cmd_addr),
    .cmd_len              (cmd_len),
    .word_take            (word_take),
    .word_data            (word_data),
    .word_avail           (word_avail),
    .rom_en               (rom_en),
    .rom_addr             (rom_addr),
    .rom_data             (rom_data),
    .busy                 (busy),
    .underrun             (underrun),
    .cmd_ignored          (cmd_ignored)
  );

  always #5 tck = ~tck;

  // Synchronous-read ROM model.
  always @(posedge tck) begin
    if (rom_en) rom_data <= rom[rom_addr];
  end

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic send_cmd(input logic [3:0] op, input logic [9:0] a, input logic [7:0] l);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_addr = a; cmd_len = l;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) tick();
  endtask

  // Issues a command, then takes words at a random rate until all expected words arrive.
  task automatic run_burst(input logic [3:0] op, input logic [9:0] a, input logic [7:0] l,
                           input int inject_at, input int take_pct);
    int n, issued, taken;
    got_q.delete(); iss_q.delete();
    max_out = 0; ign_pulses = 0; timed_out = 1'b0;
    n = (op == 4'hB) ? int'(l) + 1 : 1;
    issued = 0; taken = 0;
    send_cmd(op, a, l);
    for (int cyc = 0; cyc < 4000 && taken < n; cyc++) begin
      if (rom_en) begin iss_q.push_back(rom_addr); issued++; end
      if (cmd_ignored) ign_pulses++;
      if (issued - taken > max_out) max_out = issued - taken;
      word_take = 1'b0; cmd_valid = 1'b0;
      if (cyc == inject_at) begin
        cmd_valid = 1'b1; cmd_opcode = 4'h7;
        cmd_addr = 10'($urandom); cmd_len = 8'($urandom);
      end
      if (word_avail && ($urandom_range(0, 99) < take_pct)) begin
        word_take = 1'b1; got_q.push_back(word_data); taken++;
      end
      tick();
    end
    word_take = 1'b0; cmd_valid = 1'b0;
    if (cmd_ignored) ign_pulses++;
    if (taken < n) timed_out = 1'b1;
    wait_idle();
  endtask

  // Compares one finished run against the model: expected words rom[(a+i) mod 1024].
  task automatic score_run(input string name, input logic [3:0] op, input logic [9:0] a, input logic [7:0] l);
    int n;
    n = (op == 4'hB) ? int'(l) + 1 : 1;
    checks++;
    if (timed_out !== 1'b0 || got_q.size() != n) begin
      errors++; $display("FAIL %s words: got %0d required %0d (timeout=%0d)", name, got_q.size(), n, timed_out);
    end
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== rom[(int'(a) + i) % 1024]) begin
        errors++; $display("FAIL %s word%0d: got %h required %h", name, i, got_q[i], rom[(int'(a) + i) % 1024]);
      end
    end
    checks++;
    if (iss_q.size() != n) begin
      errors++; $display("FAIL %s issues: got %0d required %0d", name, iss_q.size(), n);
    end
    for (int i = 0; i < n && i < iss_q.size(); i++) begin
      checks++;
      if (int'(iss_q[i]) != (int'(a) + i) % 1024) begin
        errors++; $display("FAIL %s addr%0d: got %h required %h", name, i, iss_q[i], (int'(a) + i) % 1024);
      end
    end
    checks++;
    if (max_out > 2) begin
      errors++; $display("FAIL %s outstanding: got %0d required <=2", name, max_out);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL %s busy_end: got %b required 0", name, busy);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    logic [47:0] got, req;
    got = {rom_en, rom_addr, word_avail, busy, underrun, cmd_ignored, word_data};
    req = {1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF};
    checks++;
    if (got !== req) begin
      errors++; $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic test_reset();
    tap_test_logic_reset = 1'b1;
    tick(); tick();
    check_reset_outputs("reset_state");
    tap_test_logic_reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    send_cmd(4'hA, 10'h005, 8'h00);
    checks++;
    if (rom_en !== 1'b1 || rom_addr !== 10'h005) begin
      errors++; $display("FAIL single_issue: got en=%b addr=%h required en=1 addr=005", rom_en, rom_addr);
    end
    checks++;
    if (word_avail !== 1'b0) begin errors++; $display("FAIL single_avail_t1: got %b required 0", word_avail); end
    tick();
    checks++;
    if (word_avail !== 1'b0) begin errors++; $display("FAIL single_avail_t2: got %b required 0", word_avail); end
    tick();
    checks++;
    if (word_avail !== 1'b1) begin errors++; $display("FAIL single_avail_t3: got %b required 1", word_avail); end
    word_take = 1'b1;
    checks++;
    if (word_data !== 32'h1234_5678) begin
      errors++; $display("FAIL single_data: got %h required 12345678", word_data);
    end
    tick();
    word_take = 1'b0;
    wait_idle();
    checks++;
    if (busy !== 1'b0 || underrun !== 1'b0 || word_avail !== 1'b0) begin
      errors++; $display("FAIL single_end: got busy=%b underrun=%b avail=%b required 0 0 0", busy, underrun, word_avail);
    end
  endtask

  task automatic test_burst_wrap();
    run_burst(4'hB, 10'h3FE, 8'd3, -1, 100);
    score_run("burst_wrap", 4'hB, 10'h3FE, 8'd3);
    run_burst(4'hB, 10'h3FD, 8'd5, -1, 25);
    score_run("burst_wrap_slow", 4'hB, 10'h3FD, 8'd5);
  endtask

  task automatic test_kill();
    int seen;
    bit found;
    seen = 0; found = 1'b0;
    send_cmd(4'hB, 10'h100, 8'd7);
    for (int i = 0; i < 20 && !found; i++) begin
      if (rom_en) seen++;
      if (seen == 2) found = 1'b1; else tick();
    end
    checks++;
    if (!found) begin errors++; $display("FAIL kill_setup: got %0d issues required 2", seen); end
    tick();
    send_cmd(4'hA, 10'h010, 8'h00);
    for (int i = 0; i < 10 && !word_avail; i++) tick();
    checks++;
    if (word_avail !== 1'b1 || word_data !== rom[16]) begin
      errors++; $display("FAIL kill_first: got avail=%b data=%h required 1 %h", word_avail, word_data, rom[16]);
    end
    word_take = 1'b1;
    tick();
    word_take = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (word_avail !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL kill_drop: got avail=%b busy=%b required 0 0", word_avail, busy);
    end
  endtask

  task automatic test_ignored();
    logic [9:0] a;
    a = 10'($urandom);
    run_burst(4'hB, a, 8'd5, 2, 60);
    score_run("ignored_burst", 4'hB, a, 8'd5);
    checks++;
    if (ign_pulses != 1) begin
      errors++; $display("FAIL ignored_pulse: got %0d cycles required 1", ign_pulses);
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic [9:0] a;
    logic [7:0] l;
    for (int k = 0; k < 8; k++) begin
      op = ($urandom_range(0, 1) == 0) ? 4'hA : 4'hB;
      a  = 10'($urandom);
      l  = 8'($urandom_range(0, 15));
      run_burst(op, a, l, -1, $urandom_range(30, 100));
      score_run("random", op, a, l);
    end
    a = 10'($urandom);
    run_burst(4'hB, a, 8'd255, -1, 100);
    score_run("burst_256", 4'hB, a, 8'd255);
  endtask

  task automatic test_underrun();
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_pre: got %b required 0", underrun); end
    send_cmd(4'hA, 10'h020, 8'h00);
    word_take = 1'b1;
    checks++;
    if (word_data !== 32'hDEAD_BEEF || word_avail !== 1'b0) begin
      errors++; $display("FAIL underrun_data: got %h avail=%b required deadbeef 0", word_data, word_avail);
    end
    tick();
    word_take = 1'b0;
    checks++;
    if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_set: got %b required 1", underrun); end
    tick();
    checks++;
    if (word_avail !== 1'b1 || word_data !== rom[32]) begin
      errors++; $display("FAIL underrun_late_word: got avail=%b data=%h required 1 %h", word_avail, word_data, rom[32]);
    end
    word_take = 1'b1;
    tick();
    word_take = 1'b0;
    run_burst(4'hB, 10'h040, 8'd2, -1, 100);
    score_run("after_underrun", 4'hB, 10'h040, 8'd2);
    checks++;
    if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky: got %b required 1", underrun); end
  endtask

  task automatic test_reset_mid();
    bit stray;
    stray = 1'b0;
    send_cmd(4'hB, 10'h200, 8'd20);
    for (int i = 0; i < 5; i++) begin
      word_take = word_avail;
      tick();
    end
    word_take = 1'b0;
    tap_test_logic_reset = 1'b1;
    tick();
    tap_test_logic_reset = 1'b0;
    check_reset_outputs("reset_mid");
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rom_en || word_avail || busy) stray = 1'b1;
    end
    checks++;
    if (stray) begin errors++; $display("FAIL reset_quiet: got activity required none"); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    rom[5] = 32'h1234_5678;
    tap_test_logic_reset = 1'b1;
    cmd_valid = 1'b0; cmd_opcode = 4'h0; cmd_addr = 10'h000; cmd_len = 8'h00;
    word_take = 1'b0;
    test_reset();
    test_single();
    test_burst_wrap();
    test_kill();
    test_ignored();
    test_random();
    test_underrun();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
